// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Walks every register-file entry via the read wordlines, captures
//            the shared bitline and streams each value on a valid/ready port.
//            Optional running checksum enabled by `define DUMP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [NUM_REGS-1:0]         Wordline,
    input  logic [WIDTH-1:0]            Bitline,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_REGS)-1:0] out_idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            checksum
);

    localparam int                 c_IDX_W = $clog2(NUM_REGS);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_data;
    logic [c_IDX_W-1:0] r_out_idx;
    logic [NUM_REGS-1:0] w_wordline;
    logic               w_start_ok;
    logic               w_accept;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_accept   = (r_state == S_HOLD) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_READ;
            S_READ: w_next = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    w_next = (r_idx == c_LAST) ? S_DONE : S_READ;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Wordline is decoded straight from the state register so an async reset
    // releases the bitline in the same cycle.
    always_comb begin
        w_wordline = '0;
        if (r_state == S_READ) begin
            w_wordline[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_data    <= '0;
            r_out_idx <= '0;
        end else begin
            if (w_start_ok) begin
                r_idx <= '0;
            end else if (w_accept && (r_idx != c_LAST)) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_READ) begin
                r_data    <= Bitline;
                r_out_idx <= r_idx;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign Wordline  = w_wordline;
    assign out_data  = r_data;
    assign out_idx   = r_out_idx;
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Self-checking bench for regfile_dump_reader with a behavioural
//            register-file model and beat-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

    localparam int N = 16;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         out_ready;
    logic [N-1:0] Wordline;
    logic [W-1:0] Bitline;
    logic [W-1:0] out_data;
    logic [3:0]   out_idx;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic [W-1:0] checksum;

    logic [W-1:0] rf [N];
    int n_total = 0;
    int n_bad   = 0;

    regfile_dump_reader #(.NUM_REGS(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .Wordline(Wordline),
        .Bitline(Bitline), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Register file read port: undriven bitline reads as a junk pattern.
    always_comb begin
        Bitline = 16'hDEAD;
        for (int i = 0; i < N; i++) begin
            if (Wordline[i]) Bitline = rf[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum();
        logic [W-1:0] s;
        s = '0;
`ifdef DUMP_CHECKSUM_EN
        for (int i = 0; i < N; i++) s = s + rf[i];
`endif
        return {16'h0, s};
    endfunction

    // mode 0: ready always high, mode 1: random ready.
    task automatic do_dump(input int mode, input int stall_beat, input bit restart);
        int   beats;
        int   stall_cnt;
        bit   acc;
        bit   prev_wl;
        bit   finished;
        int   exp_cyc;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0; stall_cnt = 0; acc = 0; prev_wl = 0; finished = 0;
        exp_cyc = 2 * N + 1 + ((stall_beat >= 0) ? 5 : 0);
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (acc) beats++;
            check("onehot", {31'h0, $countones(Wordline) <= 1}, 32'd1);
            check("busy", {31'h0, busy}, 32'd1);
            if (cyc == 1) check("first_read", {16'h0, Wordline}, 32'd1);
            if (acc && beats < N) check("read_after_acc", {16'h0, Wordline}, 32'd1 << beats);
            if (acc && beats == N) check("done_after_last", {31'h0, done}, 32'd1);
            if (prev_wl) check("valid_after_read", {31'h0, out_valid}, 32'd1);
            if (Wordline != 0) begin
                check("wl_idx", {16'h0, Wordline}, 32'd1 << beats);
                check("valid_in_read", {31'h0, out_valid}, 32'd0);
            end
            if (out_valid) begin
                check("hold_wl", {16'h0, Wordline}, 32'd0);
                check("idx", {28'h0, out_idx}, beats);
                check("data", {16'h0, out_data}, {16'h0, rf[beats % N]});
            end
            if (done) begin
                check("beats_at_done", beats, N);
                check("valid_in_done", {31'h0, out_valid}, 32'd0);
                if (mode == 0) check("done_cycle", cyc, exp_cyc);
                check("checksum", {16'h0, checksum}, exp_sum());
                finished = 1;
            end
            prev_wl = (Wordline != 0);
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && beats == stall_beat && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            start = (restart && ((out_valid && beats == 7) || done)) ? 1'b1 : 1'b0;
            acc = out_valid && out_ready;
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_busy", {31'h0, busy}, 32'd0);
        check("idle_done", {31'h0, done}, 32'd0);
        check("idle_wl", {16'h0, Wordline}, 32'd0);
        check("idle_valid", {31'h0, out_valid}, 32'd0);
        check("cs_hold", {16'h0, checksum}, exp_sum());
        repeat (2) @(posedge clk);
        #1;
        check("still_idle", {31'h0, busy}, 32'd0);
        check("no_extra_done", {31'h0, done}, 32'd0);
    endtask

    task automatic reset_mid_dump();
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40 && Wordline !== 16'h0200; c++) begin
            @(posedge clk); #1;
        end
        check("reach_idx9", {16'h0, Wordline}, 32'h200);
        #1 rst = 1'b1;
        #1;
        check("rst_wl", {16'h0, Wordline}, 32'd0);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_data", {16'h0, out_data}, 32'd0);
        check("rst_cs", {16'h0, checksum}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = 16'h1000 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        check("reset_wl", {16'h0, Wordline}, 32'd0);
        check("reset_valid", {31'h0, out_valid}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_data", {16'h0, out_data}, 32'd0);
        check("reset_idx", {28'h0, out_idx}, 32'd0);
        check("reset_cs", {16'h0, checksum}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_dump(0, -1, 1'b0);
        do_dump(0, 3, 1'b0);
        do_dump(0, -1, 1'b1);
        reset_mid_dump();
        do_dump(0, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) rf[i] = 16'($urandom);
            do_dump(1, -1, 1'b0);
        end

        for (int i = 0; i < N; i++) rf[i] = 16'hFFFF;
        do_dump(0, -1, 1'b0);
`ifdef DUMP_CHECKSUM_EN
        check("wrap_cs", {16'h0, checksum}, 32'hFFF0);
`else
        check("wrap_cs", {16'h0, checksum}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-side controller for the 16-entry register file. On `start` it walks every register in order: it asserts one read wordline at a time, captures the shared read bitline and streams each value out on a valid/ready port. It is used for debug dumps and end-of-test register-file checks, and sits on the bitline 1 read port alongside the pipeline's read decode.

## Interface
Parameters:
- `NUM_REGS`, default 16. Number of registers walked. Must be ≥2 and a power of 2.
- `WIDTH`, default 16. Register and bitline width.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begins a dump. Sampled only in IDLE.
- `Wordline`  out  NUM_REGS  one-hot read enable; bit i drives register i's ReadEnable1.
- `Bitline`  in  WIDTH  shared read bitline 1.
- `out_data`  out  WIDTH  captured register value.
- `out_idx`  out  log2(NUM_REGS)  index of the register in `out_data`.
- `out_valid`  out  1  `out_data` and `out_idx` are valid.
- `out_ready`  in  1  consumer accepts the current beat.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `checksum`  out  WIDTH  running sum (see Configuration).

## Operation
- FSM states: IDLE, READ, HOLD, DONE. State is registered.
- IDLE: `Wordline`=0. On `start`=1, go to READ and clear the index to 0.
- READ: `Wordline` = one-hot(idx). `Bitline` is sampled at the end of this cycle into `out_data`, and `out_idx` is set to idx. Next state is HOLD. READ lasts exactly 1 cycle.
- HOLD: `Wordline`=0 and `out_valid`=1. `out_data` and `out_idx` hold stable while `out_ready`=0, with no timeout.
  - On `out_valid`&&`out_ready`, if idx==NUM_REGS-1, go to DONE.
  - Otherwise increment idx and go to READ.
- DONE: `done`=1 for 1 cycle, then IDLE.
- `start` is ignored while `busy`=1. `start` in the same cycle as DONE is also ignored.
- The index counter is log2(NUM_REGS) bits wide and never wraps within a dump. It stops at NUM_REGS-1.
- Reset values: state=IDLE; `Wordline`, `out_data`, `out_idx`, `out_valid`, `busy`, `done` and `checksum` are all 0.
- Reset mid-dump clears everything asynchronously. `Wordline` drops to 0 in the same cycle, so no register drives the bitline. No partial `done` is produced.
- At most one `Wordline` bit is ever high. All-zero is required outside READ so the pipeline's own decode can share the bitline.

## Timing
- `start` at edge k puts READ(idx 0) in cycle k+1, and `out_valid` rises at edge k+2.
- Beat latency from READ to `out_valid` is 1 cycle.
- Minimum period is 2 cycles per register. With `out_ready` tied high, a full dump takes 2·NUM_REGS cycles plus 1 DONE cycle, which is 33 cycles for 16 registers.
- `out_valid` drops on the edge after acceptance. It is never high in READ, DONE or IDLE.
- `done` is asserted in the cycle after the last handshake. `busy` falls one cycle after `done`.
- `Bitline` must settle within the READ cycle, because the tristate read path is combinational.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - `checksum` is cleared on the accepted `start`.
  - Each accepted beat adds `out_data` into `checksum`, modulo 2^WIDTH (carry discarded).
  - The final value is valid from DONE onward and holds until the next `start` or reset.
- `DUMP_CHECKSUM_EN` undefined: `checksum` is tied to 0 and no adder logic is present.

## Test plan
- Reset, `out_ready`=1, registers preloaded with value = 0x1000+i, `start` pulsed. Expected: 16 beats with idx 0..15 and data 0x1000..0x100F, `done` at cycle 33, and `checksum`=0x0078 (with the macro).
- Backpressure: `out_ready` low for 5 cycles on beat 3. Expected: `out_data`/`out_idx` stable at idx 3, `Wordline`=0 throughout the stall, and the next READ starts the cycle after acceptance.
- `start` re-pulsed during beat 7 and again in the DONE cycle. Expected: ignored; exactly 16 beats and 1 `done` pulse.
- Async `rst` asserted mid-READ at idx 9. Expected: `Wordline`=0, `out_valid`=0, `busy`=0 immediately; a later `start` dumps from idx 0.
- Wordline check every cycle during a random-`out_ready` dump: popcount(`Wordline`) ≤ 1, and it equals 1 only in READ.
- Checksum wrap: all registers 0xFFFF. Expected: `checksum`=0xFFF0 with the macro defined; 0 without it.
